// File: rtl/cash_coin_pkg.sv
// -----------------------------------------------------------------------------
// cash_coin_pkg
// Declarations shared by the coin acceptor front end and its timer:
//   coin_state_t : FSM state encoding (3 bits)
//   COIN_NICKEL  : raw size code for a nickel
//   COIN_DIME    : raw size code for a dime
//   CNT_W        : width of the shared debounce/gap counter
// -----------------------------------------------------------------------------
package cash_coin_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] COIN_NICKEL = 2'b01;
  localparam logic [1:0] COIN_DIME   = 2'b10;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    DEBOUNCE     = 3'd1,
    EMIT         = 3'd2,
    WAIT_RELEASE = 3'd3,
    GAP          = 3'd4
  } coin_state_t;

endpackage

// File: rtl/coin_timer.sv
// -----------------------------------------------------------------------------
// coin_timer
// Loadable CNT_W-bit up-counter with a terminal flag. The coin acceptor shares
// one instance between the debounce and the post-release gap phases.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-low reset (clears the count)
//   load     : load load_val this edge (has priority over inc)
//   load_val : value to load
//   inc      : increment this edge
//   limit    : terminal value; last is high when count+1 == limit
//   last     : terminal flag (combinational from the count)
// -----------------------------------------------------------------------------
module coin_timer
  import cash_coin_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare one bit wider so count+1 cannot wrap onto a small limit.
  assign last = ({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, limit};

endmodule

// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
// Front end for the vending FSM: debounces the raw coin sensor, classifies the
// coin and issues one single-cycle credit (or reject) pulse per coin. Credit is
// held back while the downstream machine is dispensing (io_lock).
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable samples to accept a coin (2..15)
//   GAP_CYCLES      : idle cycles after release before sensing again (1..15)
// Ports:
//   clk             : clock, rising edge
//   reset           : synchronous, active-low reset
//   io_coin_present : raw sensor, coin in chute
//   io_coin_size    : raw size code (01 nickel, 10 dime, else invalid)
//   io_lock         : downstream dispensing; stalls the pulse
//   io_nickel       : one-cycle nickel credit
//   io_dime         : one-cycle dime credit
//   io_reject       : one-cycle invalid-coin pulse
//   io_busy         : high whenever the FSM is not IDLE
// Optional (macro COIN_ACCEPTOR_COUNT_EN):
//   io_credit_count : saturating count of nickel+dime pulses
// -----------------------------------------------------------------------------
module coin_acceptor
  import cash_coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       io_coin_present,
  input  logic [1:0] io_coin_size,
  input  logic       io_lock,
  output logic       io_nickel,
  output logic       io_dime,
  output logic       io_reject,
  output logic       io_busy
`ifdef COIN_ACCEPTOR_COUNT_EN
  ,
  output logic [7:0] io_credit_count
`endif
);

  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYCLES);

  coin_state_t      state_q, state_d;
  logic [1:0]       size_q, size_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_inc;
  logic [CNT_W-1:0] tmr_limit;
  logic             tmr_last;

  // The timer is compared against the gap length only while in GAP; every
  // other state that uses it is debouncing.
  assign tmr_limit = (state_q == GAP) ? GAP_LIM : DEB_LIM;

  coin_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .inc      (tmr_inc),
    .limit    (tmr_limit),
    .last     (tmr_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      size_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_inc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io_coin_present) begin
          size_d       = io_coin_size;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(1);
          state_d      = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!io_coin_present) begin
          state_d = IDLE;                 // glitch, no output
        end else if (io_coin_size != size_q) begin
          // Size still settling: restart the stability window.
          size_d       = io_coin_size;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(1);
        end else if (tmr_last) begin
          state_d = EMIT;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      EMIT: begin
        if (!io_lock) begin
          state_d = WAIT_RELEASE;         // pulse is visible this cycle
        end
      end
      WAIT_RELEASE: begin
        if (!io_coin_present) begin
          tmr_load     = 1'b1;
          tmr_load_val = '0;
          state_d      = GAP;
        end
      end
      GAP: begin
        if (tmr_last) begin
          state_d = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: registered state plus io_lock (io_lock is a registered
  // signal of the downstream FSM, so no loop through this path).
  always_comb begin
    io_nickel = 1'b0;
    io_dime   = 1'b0;
    io_reject = 1'b0;
    io_busy   = (state_q != IDLE);
    if (state_q == EMIT && !io_lock) begin
      io_nickel = (size_q == COIN_NICKEL);
      io_dime   = (size_q == COIN_DIME);
      io_reject = (size_q != COIN_NICKEL) && (size_q != COIN_DIME);
    end
  end

`ifdef COIN_ACCEPTOR_COUNT_EN
  logic [7:0] credit_count_q;
  logic [7:0] credit_count_d;

  always_comb begin
    credit_count_d = credit_count_q;
    if ((io_nickel || io_dime) && (credit_count_q != 8'hFF)) begin
      credit_count_d = credit_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      credit_count_q <= 8'd0;
    end else begin
      credit_count_q <= credit_count_d;
    end
  end

  assign io_credit_count = credit_count_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
// Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4, GAP_CYCLES=2.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// A negedge monitor tallies pulses so pulse counts and one-hot can be checked.
// Optional port io_credit_count is exercised when COIN_ACCEPTOR_COUNT_EN is set.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_coin_acceptor;

  logic       clk;
  logic       reset;
  logic       io_coin_present;
  logic [1:0] io_coin_size;
  logic       io_lock;
  logic       io_nickel;
  logic       io_dime;
  logic       io_reject;
  logic       io_busy;
`ifdef COIN_ACCEPTOR_COUNT_EN
  logic [7:0] io_credit_count;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  int nickel_seen = 0;
  int dime_seen   = 0;
  int reject_seen = 0;
  int onehot_viol = 0;

  int exp_nickel = 0;
  int exp_dime   = 0;
  int exp_reject = 0;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (4),
    .GAP_CYCLES      (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .io_coin_present (io_coin_present),
    .io_coin_size    (io_coin_size),
    .io_lock         (io_lock),
    .io_nickel       (io_nickel),
    .io_dime         (io_dime),
    .io_reject       (io_reject),
    .io_busy         (io_busy)
`ifdef COIN_ACCEPTOR_COUNT_EN
    ,
    .io_credit_count (io_credit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (io_nickel) nickel_seen++;
    if (io_dime)   dime_seen++;
    if (io_reject) reject_seen++;
    if ((int'(io_nickel) + int'(io_dime) + int'(io_reject)) > 1) onehot_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic n, input logic d,
                            input logic r, input logic b);
    check_eq({tag, ".nickel"}, {31'd0, io_nickel}, {31'd0, n});
    check_eq({tag, ".dime"},   {31'd0, io_dime},   {31'd0, d});
    check_eq({tag, ".reject"}, {31'd0, io_reject}, {31'd0, r});
    check_eq({tag, ".busy"},   {31'd0, io_busy},   {31'd0, b});
  endtask

  task automatic check_tally(input string tag);
    check_eq({tag, ".nickels"}, nickel_seen, exp_nickel);
    check_eq({tag, ".dimes"},   dime_seen,   exp_dime);
    check_eq({tag, ".rejects"}, reject_seen, exp_reject);
  endtask

  // Whole coin: 4 stable edges, pulse cycle, release, gap back to IDLE.
  task automatic insert_coin(input logic [1:0] size);
    io_coin_present = 1'b1;
    io_coin_size    = size;
    step(4);
    io_coin_present = 1'b0;
    step(4);
  endtask

  initial begin
    reset           = 1'b0;
    io_coin_present = 1'b0;
    io_coin_size    = 2'b00;
    io_lock         = 1'b0;
    step(2);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1);

    // Basic nickel: pulse one cycle after the 4th edge, busy falls after gap.
    io_coin_present = 1'b1;
    io_coin_size    = 2'b01;
    step(1);
    check_outs("nickel.e0", 1'b0, 1'b0, 1'b0, 1'b1);
    step(2);
    check_outs("nickel.e2", 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    check_outs("nickel.e3", 1'b1, 1'b0, 1'b0, 1'b1);
    exp_nickel++;
    io_coin_present = 1'b0;
    step(1);
    check_outs("nickel.wait", 1'b0, 1'b0, 1'b0, 1'b1);
    step(2);
    check_outs("nickel.gap", 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    check_outs("nickel.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check_tally("nickel");

    // Glitch: two edges present, then gone.
    io_coin_present = 1'b1;
    io_coin_size    = 2'b01;
    step(2);
    check_outs("glitch.deb", 1'b0, 1'b0, 1'b0, 1'b1);
    io_coin_present = 1'b0;
    step(1);
    check_outs("glitch.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    check_tally("glitch");

    // Size bounce: 01,01,10,10,10,10 -> one dime after the 4th dime sample.
    io_coin_present = 1'b1;
    io_coin_size    = 2'b01;
    step(2);
    io_coin_size    = 2'b10;
    step(3);
    check_outs("bounce.e5", 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    check_outs("bounce.e6", 1'b0, 1'b1, 1'b0, 1'b1);
    exp_dime++;
    io_coin_present = 1'b0;
    step(4);
    check_outs("bounce.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check_tally("bounce");

    // Lock stall: dime debounced under lock, fires when lock drops.
    io_lock         = 1'b1;
    io_coin_present = 1'b1;
    io_coin_size    = 2'b10;
    step(4);
    check_outs("lock.c0", 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    check_outs("lock.c1", 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    check_outs("lock.c2", 1'b0, 1'b0, 1'b0, 1'b1);
    io_lock = 1'b0;
    #1;
    check_outs("lock.release", 1'b0, 1'b1, 1'b0, 1'b1);
    exp_dime++;
    step(1);
    check_outs("lock.after", 1'b0, 1'b0, 1'b0, 1'b1);
    io_coin_present = 1'b0;
    step(4);
    check_tally("lock");

    // Invalid coin, then a second coin inserted during GAP.
    io_coin_present = 1'b1;
    io_coin_size    = 2'b11;
    step(4);
    check_outs("invalid.emit", 1'b0, 1'b0, 1'b1, 1'b1);
    exp_reject++;
    io_coin_present = 1'b0;
    step(2);                       // -> WAIT_RELEASE -> GAP
    io_coin_present = 1'b1;        // second coin arrives during GAP
    io_coin_size    = 2'b01;
    step(2);                       // GAP ignores it, back in IDLE
    check_outs("gapcoin.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    check_outs("gapcoin.e2", 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    check_outs("gapcoin.e3", 1'b1, 1'b0, 1'b0, 1'b1);
    exp_nickel++;
    io_coin_present = 1'b0;
    step(4);
    check_tally("invalid");

    // Reset asserted at the 3rd debounce edge abandons the coin.
    io_coin_present = 1'b1;
    io_coin_size    = 2'b10;
    step(2);
    reset           = 1'b0;
    io_coin_present = 1'b0;
    step(1);
    check_outs("rst.mid", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(6);
    check_outs("rst.after", 1'b0, 1'b0, 1'b0, 1'b0);
    check_tally("rst");

`ifdef COIN_ACCEPTOR_COUNT_EN
    // Reset above cleared the count; credits from here on.
    check_eq("count.zero", {24'd0, io_credit_count}, 32'd0);
    insert_coin(2'b01);
    check_eq("count.one", {24'd0, io_credit_count}, 32'd1);
    insert_coin(2'b11);
    check_eq("count.reject", {24'd0, io_credit_count}, 32'd1);
    for (int i = 0; i < 253; i++) insert_coin((i % 2 == 0) ? 2'b10 : 2'b01);
    check_eq("count.254", {24'd0, io_credit_count}, 32'd254);
    insert_coin(2'b10);
    check_eq("count.255", {24'd0, io_credit_count}, 32'd255);
    insert_coin(2'b01);
    insert_coin(2'b10);
    check_eq("count.sat", {24'd0, io_credit_count}, 32'd255);
`endif

    check_eq("onehot", onehot_viol, 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
